// File: rtl/dice_roller.sv
// Five-die roller for a dice game: a free-running Galois LFSR feeds an
// animated roll. Each roll cycle reloads every unheld die. A turn can have at
// most three completed rolls. Between rolls, individual dice can be held.
module dice_roller #(
  parameter int unsigned  ROLL_CYCLES = 16,
  parameter logic [15:0]  LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        roll_trigger,
  input  logic        turn_clear,
  input  logic [4:0]  hold_toggle,
  output logic [14:0] dice_vals,
  output logic [4:0]  hold_mask,
  output logic        rolling,
  output logic        roll_done,
  output logic [1:0]  roll_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [7:0]  LAST_CYCLE = 8'(ROLL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [15:0] lfsr;
  logic [7:0]  anim, anim_d;
  logic [14:0] dice_d;
  logic [4:0]  hold_d;
  logic [1:0]  count_d;

  // Map a 4-bit random nibble onto a die face 1..6.
  function automatic logic [2:0] face(input logic [3:0] r);
    return 3'(r % 4'd6) + 3'd1;
  endfunction

  // Free-running LFSR; it keeps shifting in every state, turn_clear included.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (!reset_n) begin
      lfsr <= SEED_EFF;
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // State, dice, hold, roll-count and animation-counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      anim       <= '0;
      dice_vals  <= '0;
      hold_mask  <= '0;
      roll_count <= '0;
    end else begin
      state      <= state_d;
      anim       <= anim_d;
      dice_vals  <= dice_d;
      hold_mask  <= hold_d;
      roll_count <= count_d;
    end
  end

  // Next-state and datapath update. turn_clear overrides every state.
  always_comb begin
    // NOTE: every signal gets a hold-value default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state;
    anim_d  = anim;
    dice_d  = dice_vals;
    hold_d  = hold_mask;
    count_d = roll_count;

    if (turn_clear) begin
      state_d = IDLE;
      anim_d  = '0;
      dice_d  = '0;
      hold_d  = '0;
      count_d = '0;
    end else begin
      case (state)
        IDLE: begin
          // Holds only make sense once the dice have been rolled this turn.
          if (roll_count != 2'd0) begin
            hold_d = hold_mask ^ hold_toggle;
          end
          if (roll_trigger && (roll_count != 2'd3)) begin
            state_d = ROLL;
            anim_d  = '0;
          end
        end
        ROLL: begin
          anim_d = anim + 8'd1;
          for (int i = 0; i < 5; i++) begin
            if (!hold_mask[i]) begin
              dice_d[3*i +: 3] = face(lfsr[3*i +: 4]);
            end
          end
          if (anim == LAST_CYCLE) begin
            state_d = DONE;
          end
        end
        DONE: begin
          count_d = (roll_count == 2'd3) ? 2'd3 : roll_count + 2'd1;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status outputs come from the state register alone.
  assign rolling   = (state == ROLL);
  assign roll_done = (state == DONE);

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller. Two instances share the stimulus:
// one with seed 1 and one with seed 0. Both must follow the same reference
// model, which is built from the roll rules and an edge count since reset.
module tb_dice_roller;

  localparam int RC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        roll_trigger;
  logic        turn_clear;
  logic [4:0]  hold_toggle;

  logic [14:0] dice_a, dice_b;
  logic [4:0]  hold_a, hold_b;
  logic        rolling_a, rolling_b, done_a, done_b;
  logic [1:0]  cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  int n_edges = 0;           // non-reset rising edges since the last reset edge

  logic [14:0] exp_dice;
  logic [4:0]  exp_hold;
  int          exp_count;

  always #5 clk = ~clk;

  dice_roller #(.ROLL_CYCLES(RC), .LFSR_SEED(16'h0001)) dut_a (
    .clk(clk), .reset_n(reset_n), .roll_trigger(roll_trigger),
    .turn_clear(turn_clear), .hold_toggle(hold_toggle),
    .dice_vals(dice_a), .hold_mask(hold_a), .rolling(rolling_a),
    .roll_done(done_a), .roll_count(cnt_a)
  );

  dice_roller #(.ROLL_CYCLES(RC), .LFSR_SEED(16'h0000)) dut_b (
    .clk(clk), .reset_n(reset_n), .roll_trigger(roll_trigger),
    .turn_clear(turn_clear), .hold_toggle(hold_toggle),
    .dice_vals(dice_b), .hold_mask(hold_b), .rolling(rolling_b),
    .roll_done(done_b), .roll_count(cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The LFSR value after n shifts from the seed.
  function automatic logic [15:0] lfsr_after(input int n);
    logic [15:0] v;
    v = 16'h0001;
    for (int k = 0; k < n; k++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Dice after a roll whose last load used LFSR value l.
  function automatic logic [14:0] rolled(input logic [15:0] l, input logic [14:0] old,
                                         input logic [4:0] hold);
    logic [14:0] r;
    int          nib;
    r = old;
    for (int i = 0; i < 5; i++) begin
      if (!hold[i]) begin
        nib = int'((l >> (3 * i)) & 16'h000F);
        r[3*i +: 3] = 3'(nib % 6 + 1);
      end
    end
    return r;
  endfunction

  function automatic logic all_faces(input logic [14:0] d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) if (d[3*i +: 3] < 3'd1 || d[3*i +: 3] > 3'd6) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [14:0] expand(input logic [4:0] h);
    logic [14:0] m;
    for (int i = 0; i < 5; i++) m[3*i +: 3] = {3{h[i]}};
    return m;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (reset_n) n_edges++;
    else n_edges = 0;
    #1;
  endtask

  task automatic zero_model();
    exp_dice  = '0;
    exp_hold  = '0;
    exp_count = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/dice_a"}, 32'(dice_a), 32'(exp_dice));
    check({tag, "/dice_b"}, 32'(dice_b), 32'(exp_dice));
    check({tag, "/hold_a"}, 32'(hold_a), 32'(exp_hold));
    check({tag, "/hold_b"}, 32'(hold_b), 32'(exp_hold));
    check({tag, "/cnt_a"},  32'(cnt_a),  32'(exp_count));
    check({tag, "/cnt_b"},  32'(cnt_b),  32'(exp_count));
  endtask

  task automatic toggle(input logic [4:0] h);
    hold_toggle = h;
    cyc();
    hold_toggle = '0;
    if (exp_count >= 1) exp_hold = exp_hold ^ h;
  endtask

  // One accepted roll from IDLE, checked cycle by cycle.
  task automatic do_roll(input string tag);
    int          n_trig;
    logic [14:0] pre;
    logic [14:0] hm;
    pre = dice_a;
    hm  = expand(exp_hold);
    roll_trigger = 1'b1;
    cyc();
    roll_trigger = 1'b0;
    n_trig = n_edges;
    check({tag, "/rolling_first"}, 32'(rolling_a), 32'd1);
    check({tag, "/done_first"}, 32'(done_a), 32'd0);
    for (int j = 1; j < RC; j++) begin
      cyc();
      check({tag, "/rolling"}, 32'(rolling_a & rolling_b), 32'd1);
      check({tag, "/done_early"}, 32'(done_a | done_b), 32'd0);
      check({tag, "/held_stable"}, 32'(dice_a & hm), 32'(pre & hm));
    end
    cyc();
    exp_dice = rolled(lfsr_after(n_trig + RC - 1), exp_dice, exp_hold);
    check({tag, "/rolling_end"}, 32'(rolling_a | rolling_b), 32'd0);
    check({tag, "/done_a"}, 32'(done_a), 32'd1);
    check({tag, "/done_b"}, 32'(done_b), 32'd1);
    check({tag, "/count_not_yet"}, 32'(cnt_a), 32'(exp_count));
    check({tag, "/faces"}, 32'(all_faces(dice_a)), 32'd1);
    cyc();
    exp_count = (exp_count == 3) ? 3 : exp_count + 1;
    check({tag, "/done_once"}, 32'(done_a | done_b), 32'd0);
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [14:0] pre;
    reset_n      = 1'b0;
    roll_trigger = 1'b0;
    turn_clear   = 1'b0;
    hold_toggle  = '0;
    zero_model();

    // Reset state.
    cyc();
    cyc();
    check_all("reset");
    check("reset/rolling", 32'(rolling_a | rolling_b), 32'd0);
    check("reset/done", 32'(done_a | done_b), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Holds are ignored before the first roll.
    toggle(5'b11111);
    check("hold_pre_roll", 32'(hold_a), 32'd0);

    do_roll("roll1");

    // Hold d0 and d2 for the second roll.
    toggle(5'b00101);
    check("hold_00101", 32'(hold_a), 32'h05);
    pre = dice_a;
    do_roll("roll2");
    check("roll2/d0_kept", 32'(dice_a[2:0]), 32'(pre[2:0]));
    check("roll2/d2_kept", 32'(dice_a[8:6]), 32'(pre[8:6]));

    toggle(5'b00101);
    do_roll("roll3");

    // A fourth trigger is ignored.
    roll_trigger = 1'b1;
    cyc();
    roll_trigger = 1'b0;
    for (int j = 0; j < RC + 2; j++) begin
      check("fourth/rolling", 32'(rolling_a), 32'd0);
      check("fourth/done", 32'(done_a), 32'd0);
      check("fourth/count", 32'(cnt_a), 32'd3);
      cyc();
    end
    check_all("fourth");

    // A new turn clears everything.
    turn_clear = 1'b1;
    cyc();
    turn_clear = 1'b0;
    zero_model();
    check_all("clear");

    // turn_clear on the second ROLL cycle aborts the roll.
    do_roll("roll4");
    toggle(5'b00010);
    roll_trigger = 1'b1;
    cyc();
    roll_trigger = 1'b0;
    cyc();
    turn_clear = 1'b1;
    cyc();
    turn_clear = 1'b0;
    zero_model();
    check_all("abort");
    check("abort/rolling", 32'(rolling_a | rolling_b), 32'd0);
    for (int j = 0; j < RC + 1; j++) begin
      check("abort/no_done", 32'(done_a | done_b), 32'd0);
      cyc();
    end

    // turn_clear together with roll_trigger: the trigger is dropped.
    roll_trigger = 1'b1;
    turn_clear   = 1'b1;
    cyc();
    roll_trigger = 1'b0;
    turn_clear   = 1'b0;
    for (int j = 0; j < 3; j++) begin
      check("clr_trig/rolling", 32'(rolling_a), 32'd0);
      cyc();
    end
    check_all("clr_trig");

    // All dice held: the roll still runs and counts, but the dice stay unchanged.
    do_roll("roll5");
    toggle(5'b11111);
    check("hold_all", 32'(hold_a), 32'h1F);
    pre = dice_a;
    do_roll("all_held");
    check("all_held/unchanged", 32'(dice_a), 32'(pre));

    // Randomized turns.
    for (int it = 0; it < 10; it++) begin
      if (exp_count == 3) begin
        turn_clear = 1'b1;
        cyc();
        turn_clear = 1'b0;
        zero_model();
      end
      repeat ($urandom_range(0, 3)) cyc();
      if (exp_count >= 1) toggle(5'($urandom_range(0, 31)));
      do_roll("random");
    end

    // Reset in the middle of a roll aborts it and reseeds the LFSR.
    roll_trigger = 1'b1;
    cyc();
    roll_trigger = 1'b0;
    cyc();
    reset_n = 1'b0;
    turn_clear = 1'b1;
    cyc();
    reset_n = 1'b1;
    turn_clear = 1'b0;
    zero_model();
    check_all("mid_reset");
    check("mid_reset/rolling", 32'(rolling_a | rolling_b), 32'd0);
    for (int j = 0; j < RC + 1; j++) begin
      check("mid_reset/no_done", 32'(done_a | done_b), 32'd0);
      cyc();
    end
    do_roll("post_reset");

    // A reset_n glitch between edges has no effect.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    cyc();
    check_all("glitch");
    do_roll("post_glitch");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter ROLL_CYCLES, default 16: number of animation cycles per roll (legal range 2..255).
REQ-002 Parameter LFSR_SEED, default 16'hACE1: LFSR value loaded at reset; a seed of 0 loads 16'h0001 instead.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk only.
REQ-005 roll_trigger  input  1  roll request, one-cycle pulse from the game FSM.
REQ-006 turn_clear  input  1  new-turn pulse; clears dice, holds and roll count.
REQ-007 hold_toggle  input  5  per-die hold toggle pulses; bit i controls die i.
REQ-008 dice_vals  output  15  packed dice values {d4,d2..d0 ordered d4,d3,d2,d1,d0}, 3 bits each; 0 means not rolled, otherwise 1..6.
REQ-009 hold_mask  output  5  registered hold flags; bit i=1 means die i is frozen.
REQ-010 rolling  output  1  high while the state is ROLL.
REQ-011 roll_done  output  1  one-cycle pulse when a roll completes.
REQ-012 roll_count  output  2  number of completed rolls since the last turn_clear or reset; saturates at 3.

Function
REQ-013 The LFSR shall be a 16-bit Galois LFSR with taps mask 16'hB400; it shifts every cycle when reset_n=1, regardless of state, and never holds 0.
REQ-014 The state machine shall have three states: IDLE, ROLL and DONE.
REQ-015 In IDLE, roll_trigger=1 with roll_count<3 shall move to ROLL next cycle and clear the animation counter to 0.
REQ-016 In IDLE, roll_trigger=1 with roll_count=3 shall be ignored: no state change and no output change.
REQ-017 In ROLL, each cycle the animation counter shall increment, and every die i with hold_mask[i]=0 shall load (lfsr[3i+3:3i] mod 6)+1.
REQ-018 Held dice shall be unchanged in ROLL.
REQ-019 In ROLL, when the animation counter equals ROLL_CYCLES-1, the next state shall be DONE; ROLL therefore lasts exactly ROLL_CYCLES cycles.
REQ-020 In DONE, roll_done=1 for exactly one cycle, roll_count shall increment (saturating at 3), and the next state shall be IDLE.
REQ-021 Roll latency: a trigger sampled at edge T gives rolling high at T+1..T+ROLL_CYCLES, roll_done high at T+ROLL_CYCLES+1, and the updated roll_count from T+ROLL_CYCLES+2.
REQ-022 roll_trigger shall be ignored in ROLL and in DONE; requests are not queued.
REQ-023 hold_toggle[i] shall flip hold_mask[i] only in IDLE with roll_count>=1; it is ignored before the first roll and in ROLL and DONE.
REQ-024 If all five dice are held, a triggered roll shall still run through ROLL and DONE with dice unchanged, and roll_count shall increment.
REQ-025 turn_clear shall override all other inputs in every state, taking effect the next cycle: state IDLE, dice_vals=0, hold_mask=0, roll_count=0, animation counter=0.
REQ-026 A turn_clear during ROLL aborts the roll; no roll_done is produced.
REQ-027 If turn_clear and roll_trigger are asserted in the same cycle, turn_clear wins and the trigger is dropped.
REQ-028 rolling and roll_done shall be decoded from the state register only, with no combinational path from any input.

Reset
REQ-029 When reset_n=0 at a clock edge, the block shall set: state IDLE, LFSR=LFSR_SEED (or 1 if the seed is 0), dice_vals=0, hold_mask=0, roll_count=0, rolling=0, roll_done=0, animation counter=0.
REQ-030 Reset shall take priority over turn_clear and all other inputs, and shall abort an in-progress roll without a roll_done.
REQ-031 A reset_n low pulse that does not span a rising clock edge shall have no effect.

Verification
REQ-032 ROLL_CYCLES=4: reset, then a trigger pulse -> rolling high for 4 cycles; roll_done at cycle 5; every 3-bit die in 1..6; roll_count=1.
REQ-033 After roll 1, pulse hold_toggle=5'b00101, then trigger -> d0 and d2 are bit-identical to their pre-roll values, the other dice are in 1..6, and roll_count=2.
REQ-034 Three completed rolls, then a fourth trigger -> rolling stays 0, no roll_done, and roll_count stays 3; a hold_toggle before the first roll leaves hold_mask=0.
REQ-035 turn_clear on the 2nd ROLL cycle -> next cycle rolling=0, dice_vals=0, hold_mask=0, roll_count=0, and no roll_done; turn_clear together with roll_trigger in IDLE -> no roll starts.
REQ-036 LFSR_SEED=16'h0001: the dice after the first roll shall match the bit-exact reference model. With LFSR_SEED=0, the block shall behave identically to LFSR_SEED=1.
REQ-037 All dice held, then trigger -> dice_vals unchanged across ROLL; roll_done pulses once; roll_count increments by 1.
